// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory port: DMType codes,
// FSM state encoding and byte-enable patterns.
package dm_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_NONE    = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } dm_state_e;

endpackage

// File: rtl/dm_align.sv
// Combinational lane logic: byte enables, store-data shift, load extract, misalign flag.
// Zero latency; no flow control.
module dm_align
  import dm_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [31:0] w_rsh;

  assign w_rsh   = i_rdata >> {i_lo, 3'b000};
  assign o_wdata = i_wdata << {i_lo, 3'b000};

  always_comb begin
    o_be       = BE_NONE;
    o_rdata    = 32'h0;
    o_misalign = 1'b0;
    case (i_type)
      DM_WORD: begin
        o_be       = BE_WORD;
        o_rdata    = i_rdata;
        o_misalign = (i_lo != 2'b00);
      end
      DM_HALF, DM_HALFU: begin
        o_be       = i_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        o_misalign = i_lo[0];
        o_rdata    = (i_type == DM_HALF) ? {{16{w_rsh[15]}}, w_rsh[15:0]}
                                         : {16'h0, w_rsh[15:0]};
      end
      DM_BYTE, DM_BYTEU: begin
        o_be    = 4'(BE_BYTE0 << i_lo);
        o_rdata = (i_type == DM_BYTE) ? {{24{w_rsh[7]}}, w_rsh[7:0]}
                                      : {24'h0, w_rsh[7:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_port.sv
// RV32I data-memory port: one access at a time onto a gnt/rvalid bus, stall held
// while in flight; resp 2 cycles after accept for a zero-wait store, 3 for a load.
module dm_port
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  dm_state_e   r_state, w_next;
  logic [2:0]  r_type;
  logic [1:0]  r_lo;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_accept, w_err, w_misalign, w_capture;
  logic [2:0]  w_al_type;
  logic [1:0]  w_al_lo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh, w_rdata_ext;

  // One aligner serves both directions: request fields while idle, captured fields after.
  assign w_al_type = (r_state == ST_IDLE) ? req_type      : r_type;
  assign w_al_lo   = (r_state == ST_IDLE) ? req_addr[1:0] : r_lo;

  dm_align u_align (
    .i_type     (w_al_type),
    .i_lo       (w_al_lo),
    .i_wdata    (req_wdata),
    .i_rdata    (mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_rdata_ext),
    .o_misalign (w_misalign)
  );

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_err     = w_misalign || (req_type > DM_BYTEU);
  assign w_capture = !r_mem_we && mem_rvalid &&
                     (((r_state == ST_REQ) && mem_gnt) || (r_state == ST_WAIT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_err ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (mem_gnt) w_next = (r_mem_we || mem_rvalid) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: if (mem_rvalid) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_type       <= DM_WORD;
      r_lo         <= 2'b00;
      r_mem_we     <= 1'b0;
      r_mem_be     <= BE_NONE;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_rdata <= 32'h0;
      r_resp_err   <= w_accept && w_err;
      if (w_accept && !w_err) begin
        r_type      <= req_type;
        r_lo        <= req_addr[1:0];
        r_mem_we    <= req_we;
        r_mem_be    <= w_be;
        r_mem_addr  <= {req_addr[31:2], 2'b00};
        r_mem_wdata <= w_wdata_sh;
      end
      if (w_capture) r_resp_rdata <= w_rdata_ext;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign stall      = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign mem_req    = (r_state == ST_REQ);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_we     = r_mem_we;
  assign mem_be     = r_mem_be;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
